// File: rtl/ps2_scan_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scan_decoder
//   Turns a stream of PS/2 set-2 scan-code bytes into key events.
//   E0 (extended) and F0 (release) prefixes are folded into each event.
//   Repeated makes of the same key (typematic repeat) are suppressed.
//   Held arrow keys are tracked, and events are queued in a small
//   first-word-fall-through FIFO.
//
// Ports
//   i_clk          board clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_code         received scan-code byte
//   i_code_valid   one-cycle strobe qualifying i_code / i_code_err
//   i_code_err     parity/framing error for the strobed byte
//   i_evt_rd       pop the head event (ignored while FIFO is empty)
//   i_ovf_clr      clear the sticky overflow flag
//   o_evt_valid    FIFO non-empty
//   o_evt_code     head event key code (00 while empty)
//   o_evt_ext      head event carried the E0 prefix
//   o_evt_rel      head event is a release
//   o_arrows       held arrows {RIGHT,LEFT,DOWN,UP}
//   o_overflow     sticky: an event was dropped on a full FIFO
//   o_err_cnt      saturating count of errored strobes
// ---------------------------------------------------------------------------
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_code,
  input  logic       i_code_valid,
  input  logic       i_code_err,
  input  logic       i_evt_rd,
  input  logic       i_ovf_clr,
  output logic       o_evt_valid,
  output logic [7:0] o_evt_code,
  output logic       o_evt_ext,
  output logic       o_evt_rel,
  output logic [3:0] o_arrows,
  output logic       o_overflow,
  output logic [7:0] o_err_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRE_E0   = 2'd1,
    ST_PRE_F0   = 2'd2,
    ST_PRE_E0F0 = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              w_emit;
  logic              w_emit_ext;
  logic              w_emit_rel;

  logic [7:0]        r_last_code;
  logic              r_last_ext;
  logic              r_last_valid;
  logic              w_last_match;
  logic              w_suppress;
  logic              w_push;

  logic [9:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;
  logic              w_full;
  logic              w_drop;
  logic              w_wr;

  logic [3:0]        r_arrows;
  logic [3:0]        w_arrow_sel;
  logic              r_overflow;
  logic [7:0]        r_err_cnt;
  logic              w_timeout;

  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LAST);

  // Prefix FSM: next state and the event (if any) for the strobed byte.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_ext  = 1'b0;
    w_emit_rel  = 1'b0;
    if (i_code_valid && i_code_err) begin
      w_state_nxt = ST_IDLE;
    end else if (i_code_valid) begin
      if (i_code == 8'h00 || i_code == 8'hFF) begin
        w_state_nxt = ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_code == 8'hE0) begin
              w_state_nxt = ST_PRE_E0;
            end else if (i_code == 8'hF0) begin
              w_state_nxt = ST_PRE_F0;
            end else if (i_code == 8'hAA || i_code == 8'hEE ||
                         i_code == 8'hFA || i_code == 8'hFE) begin
              // keyboard status/response bytes, not keys
              w_state_nxt = ST_IDLE;
            end else begin
              w_emit      = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          ST_PRE_E0: begin
            if (i_code == 8'hF0) begin
              w_state_nxt = ST_PRE_E0F0;
            end else if (i_code == 8'hE0) begin
              w_state_nxt = ST_PRE_E0;
            end else begin
              w_emit      = 1'b1;
              w_emit_ext  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          ST_PRE_F0: begin
            w_emit      = 1'b1;
            w_emit_rel  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
          ST_PRE_E0F0: begin
            w_emit      = 1'b1;
            w_emit_ext  = 1'b1;
            w_emit_rel  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
          default: begin
            w_state_nxt = ST_IDLE;
          end
        endcase
      end
    end else if (w_timeout) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prefix wait timer: runs only while parked in a prefix state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == ST_IDLE || i_code_valid || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Typematic filter: only a fresh make or any release reaches the FIFO.
  assign w_last_match = r_last_valid && (r_last_code == i_code) && (r_last_ext == w_emit_ext);
  assign w_suppress   = w_emit && !w_emit_rel && w_last_match;
  assign w_push       = w_emit && !w_suppress;

  // Last-make register for typematic suppression.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_code  <= 8'h00;
      r_last_ext   <= 1'b0;
      r_last_valid <= 1'b0;
    end else if (w_emit && !w_emit_rel && !w_last_match) begin
      r_last_code  <= i_code;
      r_last_ext   <= w_emit_ext;
      r_last_valid <= 1'b1;
    end else if (w_emit && w_emit_rel && w_last_match) begin
      r_last_valid <= 1'b0;
    end else begin
      r_last_valid <= r_last_valid;
    end
  end

  // Arrow key decode (bit0=UP, bit1=DOWN, bit2=LEFT, bit3=RIGHT).
  always_comb begin
    w_arrow_sel = 4'b0000;
    case (i_code)
      8'h75:   w_arrow_sel = 4'b0001;
      8'h72:   w_arrow_sel = 4'b0010;
      8'h6B:   w_arrow_sel = 4'b0100;
      8'h74:   w_arrow_sel = 4'b1000;
      default: w_arrow_sel = 4'b0000;
    endcase
  end

  // Held-arrow state; follows every extended event, even suppressed/dropped ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arrows <= 4'b0000;
    end else if (w_emit && w_emit_ext && w_emit_rel) begin
      r_arrows <= r_arrows & ~w_arrow_sel;
    end else if (w_emit && w_emit_ext) begin
      r_arrows <= r_arrows | w_arrow_sel;
    end else begin
      r_arrows <= r_arrows;
    end
  end

  // A full FIFO can still accept a push when the head is popped in the same cycle.
  assign w_pop  = i_evt_rd && (r_count != '0);
  assign w_full = (r_count == CNT_FULL);
  assign w_drop = w_push && w_full && !w_pop;
  assign w_wr   = w_push && !w_drop;

  // FIFO storage and pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 10'h000;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {i_code, w_emit_ext, w_emit_rel};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // FIFO occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle beats the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_overflow;
    end
  end

  // Saturating error strobe counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (i_code_valid && i_code_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'h01;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

  // Head fields are forced to zero while empty so stale entries never show.
  assign o_evt_valid = (r_count != '0);
  assign o_evt_code  = o_evt_valid ? r_mem[r_rd_ptr][9:2] : 8'h00;
  assign o_evt_ext   = o_evt_valid ? r_mem[r_rd_ptr][1]   : 1'b0;
  assign o_evt_rel   = o_evt_valid ? r_mem[r_rd_ptr][0]   : 1'b0;
  assign o_arrows    = r_arrows;
  assign o_overflow  = r_overflow;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scan_decoder
//   Scoreboard bench: each stimulus that should produce an event pushes the
//   expected {code,ext,rel} into a queue; the drain task pops the DUT FIFO
//   and compares against the queue head.
// ---------------------------------------------------------------------------
module tb_ps2_scan_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 20;

  logic       clk;
  logic       rst_n;
  logic [7:0] code;
  logic       code_valid;
  logic       code_err;
  logic       evt_rd;
  logic       ovf_clr;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_rel;
  logic [3:0] arrows;
  logic       overflow;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] sb_q[$];

  ps2_scan_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_code      (code),
    .i_code_valid(code_valid),
    .i_code_err  (code_err),
    .i_evt_rd    (evt_rd),
    .i_ovf_clr   (ovf_clr),
    .o_evt_valid (evt_valid),
    .o_evt_code  (evt_code),
    .o_evt_ext   (evt_ext),
    .o_evt_rel   (evt_rel),
    .o_arrows    (arrows),
    .o_overflow  (overflow),
    .o_err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One strobed byte; returns 1 ns after the capturing edge.
  task automatic send(input logic [7:0] b, input logic e);
    code       = b;
    code_err   = e;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    code_err   = 1'b0;
  endtask

  task automatic expect_evt(input logic [7:0] c, input logic x, input logic r);
    sb_q.push_back({c, x, r});
  endtask

  // Pop every queued DUT event and compare with the scoreboard (bounded).
  task automatic drain(input string tag);
    logic [9:0] e;
    for (int k = 0; k < 32; k++) begin
      if (!evt_valid) break;
      if (sb_q.size() == 0) begin
        check_val({tag, "_extra_evt"}, {31'd0, evt_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_val(tag, {22'd0, evt_code, evt_ext, evt_rel}, {22'd0, e});
      end
      evt_rd = 1'b1;
      tick(1);
      evt_rd = 1'b0;
    end
    check_val({tag, "_missing_evts"}, sb_q.size(), 32'd0);
    check_val({tag, "_empty"}, {31'd0, evt_valid}, 32'd0);
    sb_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    code       = 8'h00;
    code_valid = 1'b0;
    code_err   = 1'b0;
    evt_rd     = 1'b0;
    ovf_clr    = 1'b0;
    tick(3);

    // reset state
    check_val("rst_valid", {31'd0, evt_valid}, 32'd0);
    check_val("rst_head", {22'd0, evt_code, evt_ext, evt_rel}, 32'd0);
    check_val("rst_arrows", {28'd0, arrows}, 32'd0);
    check_val("rst_ovf", {31'd0, overflow}, 32'd0);
    check_val("rst_err", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // make / release of a plain key
    send(8'h1C, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b0);
    check_val("make_latency", {31'd0, evt_valid}, 32'd1);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    expect_evt(8'h1C, 1'b0, 1'b1);
    drain("basic");

    // extended UP arrow with typematic repeat
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    expect_evt(8'h75, 1'b1, 1'b0);
    check_val("arrow_up_set", {28'd0, arrows}, 32'h1);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    check_val("arrow_up_repeat", {28'd0, arrows}, 32'h1);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    expect_evt(8'h75, 1'b1, 1'b1);
    check_val("arrow_up_clr", {28'd0, arrows}, 32'h0);
    drain("ext_up");

    // remaining arrows; plain 75 must not touch ARROWS
    send(8'hE0, 1'b0); send(8'h72, 1'b0); expect_evt(8'h72, 1'b1, 1'b0);
    send(8'hE0, 1'b0); send(8'h6B, 1'b0); expect_evt(8'h6B, 1'b1, 1'b0);
    send(8'hE0, 1'b0); send(8'h74, 1'b0); expect_evt(8'h74, 1'b1, 1'b0);
    check_val("arrows_3", {28'd0, arrows}, 32'hE);
    send(8'h75, 1'b0); expect_evt(8'h75, 1'b0, 1'b0);
    check_val("arrows_plain", {28'd0, arrows}, 32'hE);
    drain("arrows_a");
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h72, 1'b0); expect_evt(8'h72, 1'b1, 1'b1);
    check_val("arrow_down_clr", {28'd0, arrows}, 32'hC);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h6B, 1'b0); expect_evt(8'h6B, 1'b1, 1'b1);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h74, 1'b0); expect_evt(8'h74, 1'b1, 1'b1);
    check_val("arrows_none", {28'd0, arrows}, 32'h0);
    drain("arrows_b");

    // overflow: five makes into a depth-4 FIFO
    send(8'h15, 1'b0); expect_evt(8'h15, 1'b0, 1'b0);
    send(8'h1D, 1'b0); expect_evt(8'h1D, 1'b0, 1'b0);
    send(8'h24, 1'b0); expect_evt(8'h24, 1'b0, 1'b0);
    send(8'h2D, 1'b0); expect_evt(8'h2D, 1'b0, 1'b0);
    check_val("ovf_not_yet", {31'd0, overflow}, 32'd0);
    send(8'h2C, 1'b0);
    check_val("ovf_set", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check_val("ovf_clr", {31'd0, overflow}, 32'd0);
    // pop and push together on a full FIFO
    check_val("full_head", {22'd0, evt_code, evt_ext, evt_rel}, {22'd0, sb_q.pop_front()});
    evt_rd = 1'b1;
    send(8'h29, 1'b0);
    evt_rd = 1'b0;
    expect_evt(8'h29, 1'b0, 1'b0);
    check_val("pop_push_no_ovf", {31'd0, overflow}, 32'd0);
    // drop in the same cycle as a clear: drop wins
    ovf_clr = 1'b1;
    send(8'h2C, 1'b0);
    ovf_clr = 1'b0;
    check_val("drop_beats_clr", {31'd0, overflow}, 32'd1);
    drain("overflow");
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;

    // prefix timeout
    send(8'hE0, 1'b0);
    tick(TMO + 2);
    send(8'h6B, 1'b0); expect_evt(8'h6B, 1'b0, 1'b0);
    check_val("timeout_arrows", {28'd0, arrows}, 32'h0);
    send(8'hE0, 1'b0);
    tick(TMO / 4);
    send(8'h6B, 1'b0); expect_evt(8'h6B, 1'b1, 1'b0);
    check_val("no_timeout_arrows", {28'd0, arrows}, 32'h4);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h6B, 1'b0); expect_evt(8'h6B, 1'b1, 1'b1);
    drain("timeout");

    // errors, discard bytes and status bytes
    send(8'hF0, 1'b1);
    send(8'h1C, 1'b0); expect_evt(8'h1C, 1'b0, 1'b0);
    check_val("err_cnt_1", {24'd0, err_cnt}, 32'd1);
    send(8'hE0, 1'b0); send(8'h00, 1'b0);
    send(8'h1D, 1'b0); expect_evt(8'h1D, 1'b0, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hF0, 1'b0); send(8'hE0, 1'b0); expect_evt(8'hE0, 1'b0, 1'b1);
    drain("errors");
    for (int i = 0; i < 300; i++) send(8'h1C, 1'b1);
    check_val("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    drain("err_silent");

    // reset mid-prefix with a non-empty FIFO
    send(8'h33, 1'b0);
    send(8'hE0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_valid", {31'd0, evt_valid}, 32'd0);
    check_val("midrst_err", {24'd0, err_cnt}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send(8'h74, 1'b0); expect_evt(8'h74, 1'b0, 1'b0);
    check_val("postrst_arrows", {28'd0, arrows}, 32'h0);
    drain("postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, CLK cycles a prefix state may wait for its next byte.
REQ-003 CLK  in  1  board clock; every register clocks on its rising edge.
REQ-004 RST_N  in  1  reset; one clock, asynchronous, active-low.
REQ-005 CODE_IN  in  8  received scan-code byte from the PS/2 receiver.
REQ-006 CODE_VALID  in  1  one-cycle strobe; CODE_IN/CODE_ERR valid only this cycle.
REQ-007 CODE_ERR  in  1  parity/framing error flag for the strobed byte.
REQ-008 EVT_RD  in  1  pop head event; ignored when EVT_VALID=0.
REQ-009 OVF_CLR  in  1  clears OVERFLOW.
REQ-010 EVT_VALID  out  1  FIFO non-empty.
REQ-011 EVT_CODE  out  8  head event key code (first-word fall-through).
REQ-012 EVT_EXT  out  1  head event carried E0 prefix.
REQ-013 EVT_REL  out  1  head event is a release (F0 prefix).
REQ-014 ARROWS  out  4  held state {RIGHT,LEFT,DOWN,UP}, bit0=UP.
REQ-015 OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full.
REQ-016 ERR_CNT  out  8  saturating count of strobes with CODE_ERR=1.

Function
REQ-017 FSM states IDLE, PRE_E0, PRE_F0, PRE_E0F0; advances only on CODE_VALID with CODE_ERR=0.
REQ-018 IDLE: E0->PRE_E0; F0->PRE_F0; other byte->emit make {code,ext=0}, stay IDLE.
REQ-019 PRE_E0: F0->PRE_E0F0; E0->stay; other->emit make {code,ext=1}, ->IDLE.
REQ-020 PRE_F0: emit release {code,ext=0}, ->IDLE; PRE_E0F0: emit release {code,ext=1}, ->IDLE (E0/F0 in these states are emitted as codes).
REQ-021 Bytes 00 and FF in any state: no event, ->IDLE; bytes AA, EE, FA, FE in IDLE: no event, stay IDLE.
REQ-022 CODE_VALID with CODE_ERR=1: no event, FSM ->IDLE, ERR_CNT+1 saturating at 255.
REQ-023 Timeout counter clears on every CODE_VALID and in IDLE; in a prefix state reaching TIMEOUT_CYCLES forces IDLE, no event.
REQ-024 Typematic filter: register LAST_MAKE {code,ext,valid}; a make equal to a valid LAST_MAKE is suppressed; any other make loads LAST_MAKE; a release matching LAST_MAKE clears valid.
REQ-025 Emitted event is written to FIFO in the cycle after the CODE_VALID cycle; EVT_VALID rises that same cycle from empty.
REQ-026 EVT_RD with EVT_VALID=1 pops; next head presented the following cycle.
REQ-027 Full FIFO, push without pop: event dropped, OVERFLOW=1; push with pop same cycle: both performed, no overflow.
REQ-028 OVERFLOW clears on OVF_CLR=1 unless a drop occurs in the same cycle (drop wins).
REQ-029 ARROWS: extended make of 75/72/6B/74 sets UP/DOWN/LEFT/RIGHT, extended release clears it; updated with the push cycle, independent of FIFO fullness or typematic suppression; non-extended codes never affect ARROWS.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH, with an occupancy count 0..FIFO_DEPTH.

Reset
REQ-031 RST_N=0 asynchronously: FSM IDLE, FIFO empty, EVT_VALID=0, EVT_CODE=00, EVT_EXT=0, EVT_REL=0, ARROWS=0, OVERFLOW=0, ERR_CNT=0, LAST_MAKE invalid, timeout counter 0.
REQ-032 Reset mid-prefix or with a non-empty FIFO discards all state; first post-reset byte is decoded from IDLE.

Verification
REQ-033 Bytes 1C, F0 1C -> events {1C,ext0,rel0}, {1C,ext0,rel1}; EVT_VALID 1 cycle after the first strobe.
REQ-034 E0 75, E0 75, E0 F0 75 -> two events {75,ext1,rel0}, {75,ext1,rel1}; ARROWS=0001 after the first make, 0000 after the release.
REQ-035 Five makes 15,1D,24,2D,2C with EVT_RD=0, depth 4 -> four events held, OVERFLOW=1; OVF_CLR -> OVERFLOW=0; pop+push when full -> no new OVERFLOW.
REQ-036 E0, then no strobe for TIMEOUT_CYCLES, then 6B -> event {6B,ext0,rel0}, ARROWS unchanged.
REQ-037 F0 strobed with CODE_ERR=1, then 1C -> ERR_CNT=1, event {1C,ext0,rel0} (prefix discarded); 300 error strobes -> ERR_CNT=255.
REQ-038 RST_N low between E0 and 74 -> after release, 74 yields {74,ext0,rel0}, EVT_VALID=0 during reset.
